// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared types and sizing helpers for the sequential multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_seq_state_t;

    // Number of shift-add iterations needed to consume the whole multiplier.
    function automatic int iters(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Counter width for a given iteration count; never narrower than one bit.
    function automatic int cnt_width(input int n_iters);
        return (n_iters > 1) ? $clog2(n_iters) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(iters(32, 1));

endpackage

// File: rtl/mult_seq_if.sv
// mult_seq_if: go/ready/done handshake and operand/result bus of mult_seq.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic             go;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             is_signed;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;

    modport master (
        output go, left, right, is_signed,
        input  ready, done, out, out_hi
    );

    modport slave (
        input  go, left, right, is_signed,
        output ready, done, out, out_hi
    );
endinterface

// File: rtl/mult_seq_step.sv
// mult_seq_step: one combinational partial-product add of the shift-add loop.
module mult_seq_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int SHIFT_W        = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0]        acc_i,
    input  logic [WIDTH-1:0]          mcand_i,
    input  logic [BITS_PER_CYCLE-1:0] slice_i,
    input  logic [SHIFT_W-1:0]        shift_i,
    output logic [2*WIDTH-1:0]        acc_o
);
    localparam int AW = 2 * WIDTH;

    logic [AW-1:0] pp;

    // Partial product of the multiplicand and the current slice, aligned and accumulated.
    always_comb begin
        pp    = AW'(mcand_i) * AW'(slice_i);
        acc_o = acc_i + (pp << shift_i);
    end
endmodule

// File: rtl/mult_seq.sv
// mult_seq: multi-cycle shift-add multiplier retiring BITS_PER_CYCLE bits per cycle.
// Fixed latency: done in cycle ITERS+1 when go is accepted in cycle 0.
// Optional two's-complement mode is compiled in with MULT_SEQ_SIGNED_EN.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    mult_seq_if.slave io
);
    localparam int ITERS   = iters(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W   = cnt_width(ITERS);
    localparam int SHIFT_W = $clog2(WIDTH);
    localparam int AW      = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    mult_seq_state_t    state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [AW-1:0]      prod_fin;
    logic [AW-1:0]      out_q;
    logic [WIDTH-1:0]   left_ld;
    logic [WIDTH-1:0]   right_ld;
    logic [SHIFT_W-1:0] shift_pos;

    // Bit position of the slice being retired this cycle (counter runs down from ITERS-1).
    always_comb begin
        shift_pos = SHIFT_W'((CNT_LAST - cnt_q) * BITS_PER_CYCLE);
    end

    mult_seq_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHIFT_W        (SHIFT_W)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .slice_i (mplier_q[BITS_PER_CYCLE-1:0]),
        .shift_i (shift_pos),
        .acc_o   (acc_d)
    );

`ifdef MULT_SEQ_SIGNED_EN
    logic neg_q;
    logic left_neg;
    logic right_neg;

    // Signed mode latches magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        left_neg  = io.is_signed & io.left[WIDTH-1];
        right_neg = io.is_signed & io.right[WIDTH-1];
        left_ld   = left_neg  ? ('0 - io.left)  : io.left;
        right_ld  = right_neg ? ('0 - io.right) : io.right;
        prod_fin  = neg_q ? ('0 - acc_d) : acc_d;
    end
`else
    // Unsigned only: operands pass straight through, product is the raw accumulator.
    always_comb begin
        left_ld  = io.left;
        right_ld = io.right;
        prod_fin = acc_d;
    end
`endif

    // Control FSM plus datapath registers; out_q only changes on the DONE transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (io.go) begin
                        mcand_q  <= left_ld;
                        mplier_q <= right_ld;
                        acc_q    <= '0;
                        cnt_q    <= CNT_LAST;
                        state_q  <= BUSY;
`ifdef MULT_SEQ_SIGNED_EN
                        neg_q    <= left_neg ^ right_neg;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        out_q   <= prod_fin;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.ready  = (state_q != BUSY);
    assign io.done   = (state_q == DONE);
    assign io.out    = out_q[WIDTH-1:0];
    assign io.out_hi = out_q[AW-1:WIDTH];

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: randomized self-checking bench for mult_seq over three configurations:
// A = 32 bits / 1 bit per cycle, B = 32 bits / 4 bits per cycle, C = 8 bits / 2 bits per cycle.
module tb_mult_seq;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef MULT_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    mult_seq_if #(.WIDTH(32)) if_a ();
    mult_seq_if #(.WIDTH(32)) if_b ();
    mult_seq_if #(.WIDTH(8))  if_c ();

    mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut_a (.clk(clk), .reset_n(reset_n), .io(if_a));
    mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut_b (.clk(clk), .reset_n(reset_n), .io(if_b));
    mult_seq #(.WIDTH(8),  .BITS_PER_CYCLE(2)) dut_c (.clk(clk), .reset_n(reset_n), .io(if_c));

    function automatic int width_of(input int d);
        return (d == 2) ? 8 : 32;
    endfunction

    function automatic int iters_of(input int d);
        case (d)
            0:       return 32;
            1:       return 8;
            default: return 4;
        endcase
    endfunction

    // Reference: exact integer product, truncated to 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [31:0] am, bm;
        longint      sa, sb;
        logic [63:0] mask;
        am = (w == 32) ? a : (a & ((32'd1 << w) - 32'd1));
        bm = (w == 32) ? b : (b & ((32'd1 << w) - 32'd1));
        sa = longint'({32'd0, am});
        sb = longint'({32'd0, bm});
        if (SIGNED_EN && s) begin
            if (am[w-1]) sa = sa - (64'sd1 <<< w);
            if (bm[w-1]) sb = sb - (64'sd1 <<< w);
        end
        mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        return 64'(sa * sb) & mask;
    endfunction

    task automatic drive(input int d, input logic g, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        case (d)
            0: begin if_a.go = g; if_a.left = a; if_a.right = b; if_a.is_signed = s; end
            1: begin if_b.go = g; if_b.left = a; if_b.right = b; if_b.is_signed = s; end
            default: begin
                if_c.go = g; if_c.left = a[7:0]; if_c.right = b[7:0]; if_c.is_signed = s;
            end
        endcase
    endtask

    function automatic logic get_done(input int d);
        case (d)
            0:       return if_a.done;
            1:       return if_b.done;
            default: return if_c.done;
        endcase
    endfunction

    function automatic logic get_ready(input int d);
        case (d)
            0:       return if_a.ready;
            1:       return if_b.ready;
            default: return if_c.ready;
        endcase
    endfunction

    function automatic logic [63:0] get_prod(input int d);
        case (d)
            0:       return {if_a.out_hi, if_a.out};
            1:       return {if_b.out_hi, if_b.out};
            default: return {48'd0, if_c.out_hi, if_c.out};
        endcase
    endfunction

    // Issue one operation (cycle 0 = cycle go is presented), scramble operands after accept,
    // and stop at the first done cycle or when the budget runs out.
    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [63:0] prod, output int lat, output bit ready_ok);
        int limit;
        limit = iters_of(d) + 10;
        @(negedge clk);
        ready_ok = (get_ready(d) === 1'b1);
        drive(d, 1'b1, a, b, s);
        @(negedge clk);
        drive(d, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        lat = 1;
        while (get_done(d) !== 1'b1 && lat < limit) begin
            if (get_ready(d) !== 1'b0) ready_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        prod = get_prod(d);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (get_ready(d) !== 1'b1 || get_done(d) !== 1'b0 || get_prod(d) !== 64'd0) begin
                tests_failed++;
                $display("FAIL reset_state dut%0d: ready=%b done=%b prod=%h, want ready=1 done=0 prod=0",
                         d, get_ready(d), get_done(d), get_prod(d));
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] p; int lat; bit rok;
        run_op(0, 32'd3, 32'd5, 1'b0, p, lat, rok);
        tests_run++;
        if (lat !== 33) begin
            tests_failed++; $display("FAIL basic_latency: got %0d, want 33", lat);
        end
        tests_run++;
        if (p !== 64'd15) begin
            tests_failed++; $display("FAIL basic_product: got %h, want 15", p);
        end
        tests_run++;
        if (rok !== 1'b1) begin
            tests_failed++; $display("FAIL basic_ready: ready wrong in cycle 0 or during BUSY, want 1 then 0");
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            drive(0, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
            tests_run++;
            if (get_prod(0) !== 64'd15 || get_done(0) !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold cycle %0d: prod=%h done=%b, want prod=15 done=0", i, get_prod(0), get_done(0));
            end
        end
    endtask

    task automatic test_max();
        logic [63:0] p; int lat; bit rok;
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat, rok);
        tests_run++;
        if (lat !== 9) begin
            tests_failed++; $display("FAIL max_latency: got %0d, want 9", lat);
        end
        tests_run++;
        if (p !== 64'hFFFF_FFFE_0000_0001) begin
            tests_failed++; $display("FAIL max_product: got %h, want fffffffe00000001", p);
        end
    endtask

    task automatic test_back_to_back();
        int n; int m;
        logic [63:0] p1;
        @(negedge clk);
        drive(1, 1'b1, 32'h1234, 32'h10, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
        n = 1;
        while (get_done(1) !== 1'b1 && n < 20) begin
            if (n == 3)      drive(1, 1'b1, 32'd99, 32'd99, 1'b0);
            else if (n == 4) drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
            else if (n >= 6) drive(1, 1'b1, 32'd7, 32'd6, 1'b0);
            @(negedge clk);
            n++;
        end
        drive(1, 1'b1, 32'd7, 32'd6, 1'b0);
        p1 = get_prod(1);
        tests_run++;
        if (n !== 9 || p1 !== 64'h12340) begin
            tests_failed++; $display("FAIL b2b_first: lat=%0d prod=%h, want lat=9 prod=12340", n, p1);
        end
        tests_run++;
        if (get_ready(1) !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_ready_in_done: got %b, want 1", get_ready(1));
        end
        @(negedge clk);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
        m = 1;
        while (get_done(1) !== 1'b1 && m < 20) begin
            tests_run++;
            if (get_prod(1) !== 64'h12340) begin
                tests_failed++; $display("FAIL b2b_out_held: got %h, want 12340", get_prod(1));
            end
            @(negedge clk);
            m++;
        end
        tests_run++;
        if (m !== 9 || get_prod(1) !== 64'd42) begin
            tests_failed++; $display("FAIL b2b_second: lat=%0d prod=%h, want lat=9 prod=42", m, get_prod(1));
        end
    endtask

    task automatic test_random();
        logic [63:0] p; int lat; bit rok;
        logic [31:0] a, b; logic s;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 20; i++) begin
                case (i)
                    0:       begin a = 32'd0;         b = $urandom;      end
                    1:       begin a = 32'hFFFF_FFFF; b = 32'd1;         end
                    2:       begin a = 32'h8000_0000; b = 32'h8000_0000; end
                    3:       begin a = 32'hFFFF_FFFF; b = 32'h8000_0000; end
                    default: begin a = $urandom;      b = $urandom;      end
                endcase
                if (d == 2 && i == 2) begin a = 32'h80; b = 32'h80; end
                if (d == 2 && i == 3) begin a = 32'hFF; b = 32'h80; end
                s = 1'($urandom_range(0, 1));
                run_op(d, a, b, s, p, lat, rok);
                tests_run++;
                if (p !== model(width_of(d), a, b, s) || lat !== iters_of(d) + 1 || rok !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL random dut%0d a=%h b=%h s=%b: prod=%h lat=%0d rdy=%b, want prod=%h lat=%0d rdy=1",
                             d, a, b, s, p, lat, rok, model(width_of(d), a, b, s), iters_of(d) + 1);
                end
            end
        end
    endtask

    task automatic test_signed();
        logic [63:0] p; int lat; bit rok;
        logic [63:0] want;
        run_op(2, 32'hFD, 32'h05, 1'b1, p, lat, rok);
        want = SIGNED_EN ? 64'hFFF1 : 64'h04F1;
        tests_run++;
        if (p !== want || lat !== 5) begin
            tests_failed++; $display("FAIL signed_m3x5: prod=%h lat=%0d, want prod=%h lat=5", p, lat, want);
        end
        run_op(2, 32'h80, 32'h80, 1'b1, p, lat, rok);
        tests_run++;
        if (p !== 64'h4000) begin
            tests_failed++; $display("FAIL signed_m128sq: got %h, want 4000", p);
        end
        run_op(2, 32'hFD, 32'h05, 1'b0, p, lat, rok);
        tests_run++;
        if (p !== 64'h04F1) begin
            tests_failed++; $display("FAIL unsigned_fdx5: got %h, want 04f1", p);
        end
        run_op(2, 32'h7F, 32'h80, 1'b1, p, lat, rok);
        want = SIGNED_EN ? 64'hC080 : 64'h3F80;
        tests_run++;
        if (p !== want) begin
            tests_failed++; $display("FAIL signed_127xm128: got %h, want %h", p, want);
        end
    endtask

    task automatic test_reset_mid();
        int n; int pulses;
        logic [63:0] p; int lat; bit rok;
        @(negedge clk);
        drive(0, 1'b1, 32'h0001_2345, 32'h0000_6789, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        n = 1;
        while (n < 10) begin @(negedge clk); n++; end
        tests_run++;
        if (get_ready(0) !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_busy: ready=%b at cycle 10, want 0", get_ready(0));
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (get_ready(0) !== 1'b1 || get_done(0) !== 1'b0 || get_prod(0) !== 64'd0) begin
            tests_failed++;
            $display("FAIL rstmid_immediate: ready=%b done=%b prod=%h, want 1 0 0", get_ready(0), get_done(0), get_prod(0));
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (get_done(0) !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses !== 0 || get_prod(0) !== 64'd0) begin
            tests_failed++; $display("FAIL rstmid_no_done: pulses=%0d prod=%h, want 0 0", pulses, get_prod(0));
        end
        run_op(0, 32'd1000, 32'd1000, 1'b0, p, lat, rok);
        tests_run++;
        if (p !== 64'd1000000 || lat !== 33) begin
            tests_failed++; $display("FAIL rstmid_recover: prod=%h lat=%0d, want f4240 33", p, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_max();
        test_back_to_back();
        test_random();
        test_signed();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
